// File: rtl/ps2_key_event_gen.sv
// ps2_key_event_gen - scans debounced key levels and emits one toggle-style
// 11-bit key event word per change, with a minimum gap between events.
module ps2_key_event_gen #(
  parameter int                   NKEYS = 16,
  parameter int                   GAP   = 4,
  parameter logic [9*NKEYS-1:0]   CODES = '0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys_i,
  output logic [10:0]      ps2_key,
  output logic             event_o,
  output logic             busy_o
);

  localparam int PW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [PW-1:0] LAST_KEY = PW'(NKEYS - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_SCAN = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [NKEYS-1:0] reported;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    idx;
  logic             lvl;
  logic [GW-1:0]    gap_cnt;

  // Wrap by compare so non-power-of-two key counts never index past NKEYS-1.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_KEY) ? '0 : p + 1'b1;
  endfunction

  // The event word is loaded on the edge entering EMIT, so the strobe and the
  // new word are both visible for exactly the EMIT cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_SCAN;
      reported <= '0;
      ptr      <= '0;
      idx      <= '0;
      lvl      <= 1'b0;
      gap_cnt  <= '0;
      ps2_key  <= '0;
      event_o  <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (keys_i[ptr] != reported[ptr]) begin
            idx     <= ptr;
            lvl     <= keys_i[ptr];
            ps2_key <= {~ps2_key[10], keys_i[ptr], CODES[9*ptr +: 9]};
            event_o <= 1'b1;
            state   <= ST_EMIT;
          end else begin
            ptr <= next_ptr(ptr);
          end
        end
        ST_EMIT: begin
          event_o       <= 1'b0;
          reported[idx] <= lvl;
          ptr           <= next_ptr(idx);
          gap_cnt       <= GAP_LOAD;
          state         <= ST_GAP;
        end
        ST_GAP: begin
          event_o <= 1'b0;
          if (gap_cnt == '0) begin
            state <= ST_SCAN;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          event_o <= 1'b0;
          state   <= ST_SCAN;
        end
      endcase
    end
  end

  assign busy_o = (state == ST_EMIT) || (state == ST_GAP);

endmodule

// File: tb/tb_ps2_key_event_gen.sv
// tb_ps2_key_event_gen - directed and randomized checks of ps2_key_event_gen
// against an event-list reference model.
module tb_ps2_key_event_gen;

  localparam int NKEYS = 16;
  localparam int GAP   = 4;
  localparam int SPACE = GAP + 2;
  localparam int LAT   = NKEYS + GAP + 2;

  function automatic logic [9*NKEYS-1:0] mk_codes();
    logic [9*NKEYS-1:0] c;
    c = '0;
    for (int i = 0; i < NKEYS; i++)
      c[9*i +: 9] = (i == 3) ? 9'h175 : 9'(9'h040 + i);
    return c;
  endfunction

  localparam logic [9*NKEYS-1:0] CODES = mk_codes();

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b1;
  logic [NKEYS-1:0] keys_i  = '0;
  logic [10:0]      ps2_key;
  logic             event_o;
  logic             busy_o;

  ps2_key_event_gen #(.NKEYS(NKEYS), .GAP(GAP), .CODES(CODES)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .keys_i  (keys_i),
    .ps2_key (ps2_key),
    .event_o (event_o),
    .busy_o  (busy_o)
  );

  always #5 clk_sys = ~clk_sys;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [10:0] evq[$];
  int          evc[$];

  always @(negedge clk_sys) begin
    cyc = cyc + 1;
    if (event_o) begin
      evq.push_back(ps2_key);
      evc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  task automatic wait_events(input int n, input int budget, input string tag);
    int b;
    b = 0;
    while (evq.size() < n && b < budget) begin
      tick(1);
      b++;
    end
    chk(tag, 32'(evq.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    keys_i = '0;
    reset  = 1'b1;
    tick(3);
    reset = 1'b0;
    evq.delete();
    evc.delete();
  endtask

  function automatic logic [8:0] code_of(input int k);
    return CODES[9*k +: 9];
  endfunction

  function automatic int key_of(input logic [8:0] code);
    for (int i = 0; i < NKEYS; i++)
      if (CODES[9*i +: 9] == code) return i;
    return -1;
  endfunction

  logic [NKEYS-1:0] model_rep;
  logic [NKEYS-1:0] nk;
  logic [NKEYS-1:0] flips;
  logic             exp_tog;
  int               dl[$];
  int               n, s, prev, t0, k, ek;

  initial begin
    // 1: reset state and quiet idle
    keys_i = '0;
    reset  = 1'b1;
    tick(3);
    chk("rst_ps2_key", 32'(ps2_key), 32'h000);
    chk("rst_event", 32'(event_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;
    evq.delete();
    evc.delete();
    tick(100);
    chk("idle_ps2_key", 32'(ps2_key), 32'h000);
    chk("idle_events", 32'(evq.size()), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);

    // 2: press / release key 3
    keys_i[3] = 1'b1;
    wait_events(1, LAT + 4, "k3_press_latency");
    if (evq.size() >= 1) chk("k3_press_word", 32'(evq[0]), 32'h775);
    tick(SPACE + 2);
    keys_i[3] = 1'b0;
    wait_events(2, LAT + 4, "k3_release_latency");
    if (evq.size() >= 2) chk("k3_release_word", 32'(evq[1]), 32'h175);
    tick(3 * NKEYS);
    chk("k3_event_count", 32'(evq.size()), 32'd2);

    // 3: simultaneous changes from ptr=0 -> 2,5,9
    keys_i = '0;
    reset  = 1'b1;
    tick(2);
    keys_i = NKEYS'((1 << 2) | (1 << 5) | (1 << 9));
    tick(1);
    reset = 1'b0;
    evq.delete();
    evc.delete();
    wait_events(3, 3 * LAT, "multi_latency");
    if (evq.size() >= 3) begin
      chk("multi_first", 32'(evq[0]), 32'({1'b1, 1'b1, code_of(2)}));
      chk("multi_second", 32'(evq[1]), 32'({1'b0, 1'b1, code_of(5)}));
      chk("multi_third", 32'(evq[2]), 32'({1'b1, 1'b1, code_of(9)}));
      chk("multi_gap1", 32'(evc[1] - evc[0] >= SPACE), 32'd1);
      chk("multi_gap2", 32'(evc[2] - evc[1] >= SPACE), 32'd1);
    end
    tick(3 * NKEYS);
    chk("multi_count", 32'(evq.size()), 32'd3);

    // 4: wrap from key 15 to key 0
    do_reset();
    keys_i[14] = 1'b1;
    wait_events(1, LAT + 4, "wrap_k14");
    keys_i[15] = 1'b1;
    keys_i[0]  = 1'b1;
    wait_events(3, 3 * LAT, "wrap_latency");
    if (evq.size() >= 3) begin
      chk("wrap_k15_first", 32'(key_of(evq[1][8:0])), 32'd15);
      chk("wrap_k0_next", 32'(key_of(evq[2][8:0])), 32'd0);
    end

    // 5: press key 7, release during GAP
    do_reset();
    keys_i[7] = 1'b1;
    wait_events(1, LAT + 4, "k7_press_latency");
    tick(2);
    chk("k7_busy_in_gap", 32'(busy_o), 32'd1);
    keys_i[7] = 1'b0;
    wait_events(2, 2 * LAT, "k7_release_latency");
    if (evq.size() >= 2) begin
      chk("k7_press_word", 32'(evq[0]), 32'({1'b1, 1'b1, code_of(7)}));
      chk("k7_release_word", 32'(evq[1]), 32'({1'b0, 1'b0, code_of(7)}));
    end
    tick(3 * NKEYS);
    chk("k7_event_count", 32'(evq.size()), 32'd2);

    // 6: reset during GAP with key held
    do_reset();
    keys_i[5] = 1'b1;
    wait_events(1, LAT + 4, "k5_press_latency");
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midgap_rst_ps2_key", 32'(ps2_key), 32'h000);
    chk("midgap_rst_busy", 32'(busy_o), 32'd0);
    evq.delete();
    evc.delete();
    wait_events(1, LAT + 4, "k5_rereport_latency");
    if (evq.size() >= 1) chk("k5_rereport_word", 32'(evq[0]), 32'({1'b1, 1'b1, code_of(5)}));

    // randomized: each burst of changes must come out as one event per
    // differing key, in circular ascending order, correct level and toggle.
    do_reset();
    model_rep = '0;
    exp_tog   = 1'b0;
    prev      = -1000;
    for (int it = 0; it < 25; it++) begin
      flips = (it % 3 == 0) ? NKEYS'($urandom) : NKEYS'($urandom & $urandom & $urandom);
      nk = model_rep ^ flips;
      dl.delete();
      for (int i = 0; i < NKEYS; i++)
        if (flips[i]) dl.push_back(i);
      n = dl.size();
      evq.delete();
      evc.delete();
      t0 = cyc;
      keys_i = nk;
      wait_events(n, n * LAT + NKEYS + 8, "rand_latency");
      tick(2 * NKEYS + GAP + 4);
      chk("rand_count", 32'(evq.size()), 32'(n));
      s = 0;
      if (n > 0 && evq.size() > 0)
        for (int i = 0; i < n; i++)
          if (dl[i] == key_of(evq[0][8:0])) s = i;
      for (int j = 0; j < n && j < evq.size(); j++) begin
        k  = key_of(evq[j][8:0]);
        ek = dl[(s + j) % n];
        exp_tog = ~exp_tog;
        chk("rand_key", 32'(k), 32'(ek));
        chk("rand_level", 32'(evq[j][9]), 32'(nk[ek]));
        chk("rand_toggle", 32'(evq[j][10]), 32'(exp_tog));
        chk("rand_spacing", 32'(evc[j] - prev >= SPACE), 32'd1);
        chk("rand_bound", 32'(evc[j] - t0 <= (j + 1) * LAT), 32'd1);
        prev = evc[j];
      end
      model_rep = nk;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
